// File: rtl/trng_pkg.sv
// Shared TRNG definitions: default block sizes and the von Neumann pair-state encoding.
package trng_pkg;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_RCT_CUTOFF = 32;

    typedef enum logic {
        VN_IDLE  = 1'b0,
        VN_HAVE1 = 1'b1
    } vn_state_e;

endpackage

// File: rtl/trng_postproc_if.sv
// Raw-sample input, control and output handshake signals of the TRNG post-processor.
interface trng_postproc_if import trng_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             en;
    logic             raw_bit;
    logic             raw_valid;
    logic             clr_fail;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             health_fail;
    logic             overflow;

    modport master (
        output en, raw_bit, raw_valid, clr_fail, out_ready,
        input  out_data, out_valid, health_fail, overflow
    );

    modport slave (
        input  en, raw_bit, raw_valid, clr_fail, out_ready,
        output out_data, out_valid, health_fail, overflow
    );

endinterface

// File: rtl/trng_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered head word.
module trng_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = head_q;

    always_comb begin
        wptr_d = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
        // The word written this cycle becomes the head when nothing older remains.
        if (do_push && (rptr_d == wptr_q)) begin
            head_d = wdata_i;
        end else begin
            head_d = mem_q[rptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            head_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            head_q <= head_d;
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/trng_postproc.sv
// TRNG post-processing: repetition-count health test, von Neumann debiasing,
// word packing and output buffering behind a valid/ready handshake.
module trng_postproc import trng_pkg::*; #(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned RCT_CUTOFF = DEF_RCT_CUTOFF
) (
    input  logic            clk,
    input  logic            rst_n,
    trng_postproc_if.slave  bus
);

    localparam int unsigned CntW  = $clog2(RCT_CUTOFF + 1);
    localparam int unsigned BcntW = $clog2(WIDTH);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             hit_q, hit_d;
    logic             fail_q, fail_d;
    logic             ovf_q, ovf_d;
    vn_state_e        vn_q, vn_d;
    logic             first_q, first_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BcntW-1:0] bcnt_q, bcnt_d;

    logic             accept, flush, push, drop;
    logic             fifo_full, fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;

    assign accept = bus.raw_valid & bus.en & ~fail_q;
    assign flush  = ~bus.en | fail_q;

    // Repetition-count test; hit_q is a one-cycle event so a later clear can stick.
    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (!bus.en || bus.clr_fail) begin
            cnt_d = '0;
        end else if (bus.raw_valid) begin
            last_d = bus.raw_bit;
            if ((cnt_q == '0) || (bus.raw_bit != last_q)) begin
                cnt_d = CntW'(1);
            end else if (cnt_q != CntW'(RCT_CUTOFF)) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        hit_d  = (cnt_d == CntW'(RCT_CUTOFF)) && (cnt_q != CntW'(RCT_CUTOFF));
        fail_d = hit_q ? 1'b1 : (bus.clr_fail ? 1'b0 : fail_q);
    end

    always_comb begin
        vn_d    = vn_q;
        first_d = first_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        push    = 1'b0;
        if (flush) begin
            vn_d    = VN_IDLE;
            shreg_d = '0;
            bcnt_d  = '0;
        end else if (accept) begin
            unique case (vn_q)
                VN_IDLE: begin
                    first_d = bus.raw_bit;
                    vn_d    = VN_HAVE1;
                end
                VN_HAVE1: begin
                    vn_d = VN_IDLE;
                    if (first_q != bus.raw_bit) begin
                        shreg_d = {shreg_q[WIDTH-2:0], first_q};
                        if (bcnt_q == BcntW'(WIDTH - 1)) begin
                            bcnt_d = '0;
                            push   = 1'b1;
                        end else begin
                            bcnt_d = bcnt_q + BcntW'(1);
                        end
                    end
                end
                default: vn_d = VN_IDLE;
            endcase
        end
    end

    // A full FIFO still takes the word when the consumer pops in the same cycle.
    assign drop  = push & fifo_full & ~(bus.out_ready & ~fifo_empty);
    assign ovf_d = drop ? 1'b1 : (bus.clr_fail ? 1'b0 : ovf_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            last_q  <= 1'b0;
            hit_q   <= 1'b0;
            fail_q  <= 1'b0;
            ovf_q   <= 1'b0;
            vn_q    <= VN_IDLE;
            first_q <= 1'b0;
            shreg_q <= '0;
            bcnt_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            hit_q   <= hit_d;
            fail_q  <= fail_d;
            ovf_q   <= ovf_d;
            vn_q    <= vn_d;
            first_q <= first_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
        end
    end

    trng_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (shreg_d),
        .pop_i   (bus.out_ready),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .rdata_o (fifo_rdata)
    );

    assign bus.out_data    = fifo_rdata;
    assign bus.out_valid   = ~fifo_empty;
    assign bus.health_fail = fail_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_trng_postproc.sv
// Self-checking bench for trng_postproc against a queue-based behavioural model.
module tb_trng_postproc;

    localparam int unsigned W   = 8;
    localparam int unsigned D   = 4;
    localparam int unsigned CUT = 32;

    logic clk;
    logic rst_n;

    trng_postproc_if #(.WIDTH(W)) bus ();

    trng_postproc #(
        .WIDTH      (W),
        .FIFO_DEPTH (D),
        .RCT_CUTOFF (CUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: sample/bit/word queues instead of registers.
    int         m_run;
    bit         m_last, m_hit, m_fail, m_ovf;
    bit         m_samp_q[$];
    bit         m_bits_q[$];
    logic [7:0] m_fifo[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    task automatic model_reset();
        m_run = 0;
        m_last = 0;
        m_hit = 0;
        m_fail = 0;
        m_ovf = 0;
        m_samp_q.delete();
        m_bits_q.delete();
        m_fifo.delete();
    endtask

    // Advance one clock; the model consumes the inputs currently applied.
    task automatic tick();
        bit         pop, accept, set_ovf, word_done, new_hit;
        int         new_run;
        logic [7:0] w;
        if (!rst_n) begin
            model_reset();
            @(posedge clk);
            #1;
            return;
        end
        pop = bus.out_ready && (m_fifo.size() > 0);
        if (bus.out_ready && bus.out_valid) got_q.push_back(bus.out_data);
        if (pop) exp_q.push_back(m_fifo[0]);
        accept = bus.raw_valid && bus.en && !m_fail;
        new_run = m_run;
        if (!bus.en || bus.clr_fail) new_run = 0;
        else if (bus.raw_valid) begin
            if (m_run == 0 || bus.raw_bit != m_last) new_run = 1;
            else if (m_run < CUT) new_run = m_run + 1;
        end
        new_hit = (new_run == CUT) && (m_run != CUT);
        word_done = 0;
        w = '0;
        if (!bus.en || m_fail) begin
            m_samp_q.delete();
            m_bits_q.delete();
        end else if (accept) begin
            m_samp_q.push_back(bus.raw_bit);
            if (m_samp_q.size() == 2) begin
                if (m_samp_q[0] != m_samp_q[1]) m_bits_q.push_back(m_samp_q[0]);
                m_samp_q.delete();
            end
            if (m_bits_q.size() == W) begin
                foreach (m_bits_q[i]) w = {w[6:0], m_bits_q[i]};
                m_bits_q.delete();
                word_done = 1;
            end
        end
        if (pop) void'(m_fifo.pop_front());
        set_ovf = 0;
        if (word_done) begin
            if (m_fifo.size() < D) m_fifo.push_back(w);
            else set_ovf = 1;
        end
        m_fail = m_hit ? 1'b1 : (bus.clr_fail ? 1'b0 : m_fail);
        m_hit  = new_hit;
        m_ovf  = set_ovf ? 1'b1 : (bus.clr_fail ? 1'b0 : m_ovf);
        if (bus.en && !bus.clr_fail && bus.raw_valid) m_last = bus.raw_bit;
        m_run = new_run;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input bit b);
        bus.raw_bit = b;
        bus.raw_valid = 1'b1;
        tick();
        bus.raw_valid = 1'b0;
    endtask

    // One debiased bit x comes from the pair (x, ~x).
    task automatic send_emit(input bit x);
        strobe(x);
        strobe(!x);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = W - 1; i >= 0; i--) send_emit(w[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.out_data, bus.out_valid, bus.health_fail, bus.overflow} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h v=%b hf=%b ov=%b, expected all 0",
                     bus.out_data, bus.out_valid, bus.health_fail, bus.overflow);
        end
        @(posedge clk);
        #1;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_valid: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_basic_word();
        bit pat[4] = '{0, 1, 1, 0};
        bus.en = 1'b1;
        bus.out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                strobe(pat[k]);
                if (r == 3 && k == 2) begin
                    checks++;
                    if (bus.out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL basic_early_valid: got %b expected 0", bus.out_valid);
                    end
                end
            end
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h55) begin
            errors++;
            $display("FAIL basic_word: got v=%b data=%h expected v=1 data=55",
                     bus.out_valid, bus.out_data);
        end
        checks++;
        if (bus.out_data !== m_fifo[0]) begin
            errors++;
            $display("FAIL basic_model: got %h expected %h", bus.out_data, m_fifo[0]);
        end
        idle(2);
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL basic_pop: got %0d words expected 1 word 55", got_q.size());
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_no_bias();
        bit pat[4] = '{0, 0, 1, 1};
        int seen = 0;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 4; k++) begin
                strobe(pat[k]);
                if (bus.out_valid !== 1'b0) seen++;
            end
        end
        checks++;
        if (seen != 0 || bus.health_fail !== 1'b0) begin
            errors++;
            $display("FAIL no_bias: got %0d valid cycles hf=%b expected 0 and 0",
                     seen, bus.health_fail);
        end
    endtask

    task automatic test_rct();
        bus.en = 1'b0;
        tick();
        bus.en = 1'b1;
        for (int i = 0; i < 31; i++) strobe(1'b1);
        checks++;
        if (bus.health_fail !== 1'b0) begin
            errors++;
            $display("FAIL rct_31: got hf=%b expected 0", bus.health_fail);
        end
        strobe(1'b1);
        checks++;
        if (bus.health_fail !== 1'b0) begin
            errors++;
            $display("FAIL rct_32: got hf=%b expected 0", bus.health_fail);
        end
        tick();
        checks++;
        if (bus.health_fail !== 1'b1 || m_fail !== 1'b1) begin
            errors++;
            $display("FAIL rct_trip: got hf=%b expected 1", bus.health_fail);
        end
        for (int i = 0; i < 10; i++) send_emit(1'($urandom_range(0, 1)));
        checks++;
        if (bus.out_valid !== 1'b0 || bus.health_fail !== 1'b1) begin
            errors++;
            $display("FAIL rct_blocked: got v=%b hf=%b expected v=0 hf=1",
                     bus.out_valid, bus.health_fail);
        end
        bus.clr_fail = 1'b1;
        tick();
        bus.clr_fail = 1'b0;
        checks++;
        if (bus.health_fail !== 1'b0) begin
            errors++;
            $display("FAIL rct_clear: got hf=%b expected 0", bus.health_fail);
        end
        for (int i = 0; i < 24; i++) send_emit(1'($urandom_range(0, 1)));
        idle(3);
        checks++;
        if (got_q.size() != 3 || exp_q.size() != 3) begin
            errors++;
            $display("FAIL rct_resume_count: got %0d expected 3", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rct_resume_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_overflow();
        logic [7:0] want;
        bus.en = 1'b0;
        tick();
        bus.en = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_word(8'(i));
        checks++;
        if (bus.overflow !== 1'b1 || m_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b expected 1", bus.overflow);
        end
        bus.out_ready = 1'b1;
        idle(6);
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL ovf_drain_count: got %0d expected 4", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            want = 8'(i + 1);
            checks++;
            if (got_q[i] !== want || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf_word%0d: got %h expected %h", i, got_q[i], want);
            end
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty: got v=%b expected 0", bus.out_valid);
        end
        bus.clr_fail = 1'b1;
        tick();
        bus.clr_fail = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", bus.overflow);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_full_pop_push();
        logic [7:0] w[5];
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) send_word(w[i]);
        for (int i = W - 1; i >= 1; i--) send_emit(w[4][i]);
        strobe(w[4][0]);
        bus.out_ready = 1'b1;
        strobe(!w[4][0]);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL fullpp_flags: got ov=%b v=%b expected ov=0 v=1",
                     bus.overflow, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        idle(7);
        checks++;
        if (got_q.size() != 5) begin
            errors++;
            $display("FAIL fullpp_count: got %0d expected 5", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            checks++;
            if (got_q[i] !== w[i] || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL fullpp_word%0d: got %h expected %h", i, got_q[i], w[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midword();
        bus.en = 1'b0;
        tick();
        bus.en = 1'b1;
        bus.out_ready = 1'b0;
        send_word(8'h3C);
        for (int i = 0; i < 5; i++) send_emit(1'($urandom_range(0, 1)));
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got v=%b expected 1", bus.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({bus.out_data, bus.out_valid, bus.health_fail, bus.overflow} !== 11'd0) begin
            errors++;
            $display("FAIL rstmid_async: got data=%h v=%b hf=%b ov=%b expected all 0",
                     bus.out_data, bus.out_valid, bus.health_fail, bus.overflow);
        end
        @(posedge clk);
        #1;
        idle(2);
        checks++;
        if ({bus.out_data, bus.out_valid, bus.health_fail, bus.overflow} !== 11'd0) begin
            errors++;
            $display("FAIL rstmid_hold: got data=%h v=%b expected all 0",
                     bus.out_data, bus.out_valid);
        end
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        bus.out_ready = 1'b1;
        send_word(8'hA5);
        idle(3);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'hA5 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL rstmid_word: got %0d words first=%h expected 1 word a5",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        int vbad = 0;
        for (int c = 0; c < 1500; c++) begin
            bus.raw_valid = ($urandom_range(0, 1) == 1);
            bus.raw_bit = ($urandom_range(0, 9) < 6);
            bus.out_ready = ($urandom_range(0, 2) == 0);
            bus.en = ($urandom_range(0, 99) != 0);
            bus.clr_fail = ($urandom_range(0, 149) == 0);
            tick();
            if (bus.out_valid !== (m_fifo.size() > 0) || bus.overflow !== m_ovf ||
                bus.health_fail !== m_fail) vbad++;
        end
        bus.raw_valid = 1'b0;
        bus.clr_fail = 1'b0;
        bus.out_ready = 1'b1;
        idle(6);
        checks++;
        if (vbad != 0) begin
            errors++;
            $display("FAIL rand_flags: got %0d flag disagreements expected 0", vbad);
        end
        checks++;
        if (got_q.size() != exp_q.size() || got_q.size() == 0) begin
            errors++;
            $display("FAIL rand_count: got %0d words expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.raw_bit = 1'b0;
        bus.raw_valid = 1'b0;
        bus.clr_fail = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        test_reset();
        test_basic_word();
        test_no_bias();
        test_rct();
        test_overflow();
        test_full_pop_push();
        test_reset_midword();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
